// File: rtl/rt_pixel_writer.sv
// rt_pixel_writer: FIFO-buffers shaded pixels from the ray-trace core and writes them
// into frame-buffer port A during the write phases (SLOT_STATE[1] = 1) of the port-A schedule.
module rt_pixel_writer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned LINE_W    = 640,
    parameter int unsigned BAND_ROWS = 64
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [1:0]  SLOT_STATE,
    input  logic        PIX_VALID,
    input  logic [9:0]  PIX_X,
    input  logic [9:0]  PIX_Y,
    input  logic [11:0] PIX_RGB,
    output logic        PIX_READY,
    output logic        OCM_WE,
    output logic [15:0] OCM_ADDR,
    output logic [15:0] OCM_DATAIN,
    output logic        EMPTY,
    output logic [15:0] WR_COUNT,
    output logic [7:0]  DROP_COUNT
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic          full;
    logic          empty;
    logic          accept;
    logic          in_range;
    logic          push;
    logic          pop;
    logic [31:0]   addr_wide;
    entry_t        head;

    assign full      = (count_q == FULL_COUNT);
    assign empty     = (count_q == '0);
    assign PIX_READY = RESET_N & ~full;
    assign accept    = PIX_VALID & PIX_READY;
    assign in_range  = (32'(PIX_X) < LINE_W);
    assign push      = accept & in_range;
    assign pop       = SLOT_STATE[1] & ~empty;

    // Computed at 32 bits so LINE_W * row cannot overflow before truncation to 16.
    assign addr_wide = 32'(PIX_X) + LINE_W * (32'(PIX_Y) % BAND_ROWS);

    assign head       = mem_q[rd_ptr_q];
    assign OCM_WE     = pop;
    assign OCM_ADDR   = empty ? 16'd0 : head.addr;
    assign OCM_DATAIN = empty ? 16'd0 : head.data;
    assign EMPTY      = empty;
    assign WR_COUNT   = wr_count_q;
    assign DROP_COUNT = drop_count_q;

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        wr_count_d   = wr_count_q;
        drop_count_d = drop_count_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{addr: addr_wide[15:0], data: {4'b0000, PIX_RGB}};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            wr_count_d = wr_count_q + 16'd1;
        end
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        if (accept && !in_range && drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            wr_count_q   <= '0;
            drop_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            wr_count_q   <= wr_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage needs no reset: outputs are masked by EMPTY and stale entries are never read.
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

endmodule

// File: doc/rt_pixel_writer.md
# rt_pixel_writer

Buffers shaded pixels from a ray-trace core and writes them into on-chip frame-buffer port A, but only during the write slots of the shared 4-phase port-A schedule. Phases 2'b00/2'b01 belong to the VGA read path; phases 2'b10/2'b11 are write slots. The block sits directly upstream of the frame-buffer port-A mux and supplies its write-slot address, data and write enable. A small FIFO decouples the core's bursty output from the fixed slot cadence.

## Interface
Parameters:
- DEPTH, 8: FIFO entries (power of two, ≥2)
- LINE_W, 640: pixels per frame-buffer row
- BAND_ROWS, 64: rows held in the on-chip band (power of two); LINE_W*BAND_ROWS ≤ 65536

Ports:
- CLK  in  1  main clock (MAIN_CLK domain)
- RESET_N  in  1  reset, asynchronous, active-low
- SLOT_STATE  in  2  port-A phase counter from the frame-buffer mux
- PIX_VALID  in  1  core presents a pixel
- PIX_X  in  10  pixel column
- PIX_Y  in  10  pixel row (frame coordinates)
- PIX_RGB  in  12  {R[3:0],G[3:0],B[3:0]}
- PIX_READY  out  1  block accepts a pixel this cycle
- OCM_WE  out  1  port-A write enable for this cycle
- OCM_ADDR  out  16  port-A write address
- OCM_DATAIN  out  16  port-A write data
- EMPTY  out  1  FIFO empty
- WR_COUNT  out  16  completed writes, wrapping
- DROP_COUNT  out  8  rejected pixels, saturating at 255

## Operation
- Accept: handshake completes on the rising edge where PIX_VALID & PIX_READY.
- PIX_READY = ~full while RESET_N is high. PIX_READY = 0 while RESET_N is low.
- Range check at accept: if PIX_X ≥ LINE_W, the pixel is consumed but not enqueued, and DROP_COUNT increments (holds at 255).
- Enqueue: for an in-range pixel, the FIFO stores addr = PIX_X + LINE_W*(PIX_Y mod BAND_ROWS) as 16 bits, and data = {4'b0000, PIX_RGB}.
- Address arithmetic:
  - The multiply is done at ≥17 bits, then truncated.
  - With the defaults, the maximum address is 639 + 640*63 = 40959.
- Issue: OCM_WE = SLOT_STATE[1] & ~EMPTY (combinational).
  - OCM_ADDR and OCM_DATAIN show the FIFO head whenever ~EMPTY; they are 0 when empty.
- Pop: on every edge where OCM_WE = 1, the head is removed and WR_COUNT increments (wraps at 65535 → 0).
- Throughput: at most 2 writes per 4 cycles. Pixels are written in acceptance order.
- Simultaneous push and pop in one edge: count is unchanged and both take effect.
  - When full, a pop frees a slot on that edge; PIX_READY rises the next cycle.
- FIFO state: count 0..DEPTH, with read/write pointers wrapping modulo DEPTH.
- Reset mid-operation: FIFO contents are discarded, OCM_WE drops immediately (asynchronous), and counters clear.

## Timing
- Reset values:
  - PIX_READY 0 during reset, 1 on the first cycle after release
  - OCM_WE 0, OCM_ADDR 0, OCM_DATAIN 0
  - EMPTY 1, WR_COUNT 0, DROP_COUNT 0
- Latency, accept edge to first possible OCM_WE:
  - Best case 1 cycle: SLOT_STATE = 2'b10 or 2'b11 on the cycle after the accept edge.
  - Worst case 3 cycles: next cycle is SLOT_STATE = 2'b00.
- There is no bypass: a pixel is never written in the cycle it is presented.
- EMPTY, PIX_READY and counters are registered-state derived and update on the edge.
- OCM_WE, OCM_ADDR and OCM_DATAIN are combinational from FIFO head and SLOT_STATE, so they align with the mux's same-cycle slot selection.
- During SLOT_STATE 2'b00/2'b01, OCM_WE = 0 regardless of FIFO state.

## Test plan
- Reset/idle:
  - Stimulus: assert RESET_N=0 mid-burst with 5 entries queued, release.
  - Required: EMPTY=1, WR_COUNT=0, OCM_WE=0 in reset, PIX_READY=1 one cycle after release.
- Single pixel:
  - Stimulus: push X=5, Y=70, RGB=12'hABC one cycle before SLOT_STATE=2'b10.
  - Required: OCM_WE=1, OCM_ADDR=5+640*6=3845, OCM_DATAIN=16'h0ABC in that slot; WR_COUNT=1.
- Slot gating:
  - Stimulus: push 4 pixels back-to-back with SLOT_STATE free-running from 2'b00.
  - Required: exactly 2 writes per 4-cycle round, only in phases 10/11, in push order; EMPTY=1 after the 2nd round.
- Full/backpressure:
  - Stimulus: hold PIX_VALID=1 for 20 cycles.
  - Required: PIX_READY=0 whenever count=8, no pixel lost or duplicated; scoreboard matches all accepted pixels.
- Drop:
  - Stimulus: push X=640 and X=1023.
  - Required: both accepted, no OCM_WE, DROP_COUNT=2.
  - Stimulus: push 300 out-of-range pixels.
  - Required: DROP_COUNT=255.
- Wrap:
  - Stimulus: push Y=63 then Y=64 at X=639.
  - Required: addresses 40959 then 639.
  - Stimulus: 65536 writes.
  - Required: WR_COUNT returns to 0.
